datapath_ctrl: RTL and testbench

Control sequencer that drives the register-file/dual-ALU datapath's control inputs from a single command handshake. One accepted command expands into one or more READ/EXEC cycle pairs with correctly timed read enables, ALU selects, input-mux select, write enables and output-register load. A done pulse follows. The block sits between the top-level stimulus/host logic and the datapath, replacing hand-driven control words.

---
 rtl/datapath_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_ctrl
//  Brief    : Command sequencer for the register-file / dual-ALU datapath.
//             One accepted command expands into rpt+1 READ/EXEC cycle pairs,
//             followed by a single-cycle DONE pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module datapath_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [3:0] dst,
    input  logic [3:0] srcA,
    input  logic [3:0] srcB,
    input  logic [3:0] fn,
    input  logic [3:0] rpt,
    output logic       busy,
    output logic       done,
    output logic       IE,
    output logic [3:0] WAA,
    output logic       WEA,
    output logic [3:0] WAB,
    output logic       WEB,
    output logic [3:0] RAA,
    output logic       REA,
    output logic [3:0] RAB,
    output logic       REB,
    output logic [3:0] S_ALU1,
    output logic [3:0] S_ALU2,
    output logic       OE
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] CMD_LOAD  = 2'b00;
    localparam logic [1:0] CMD_ALU   = 2'b01;
    localparam logic [1:0] CMD_UNARY = 2'b10;
    localparam logic [1:0] CMD_OUT   = 2'b11;

    logic [1:0] r_state;
    logic [1:0] r_cmd;
    logic [3:0] r_dst;
    logic [3:0] r_src_a;
    logic [3:0] r_src_b;
    logic [3:0] r_fn;
    logic [3:0] r_cnt;

    logic [1:0] w_next_state;
    logic [1:0] w_cmd;
    logic [3:0] w_dst;
    logic [3:0] w_src_a;
    logic [3:0] w_src_b;
    logic [3:0] w_fn;
    logic [3:0] w_cnt;

    logic       w_busy;
    logic       w_done;
    logic       w_ie;
    logic [3:0] w_waa;
    logic       w_wea;
    logic [3:0] w_wab;
    logic       w_web;
    logic [3:0] w_raa;
    logic       w_rea;
    logic [3:0] w_rab;
    logic       w_reb;
    logic [3:0] w_s_alu1;
    logic [3:0] w_s_alu2;
    logic       w_oe;
    logic       w_exec;

    // State register plus the command fields captured at acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cmd   <= 2'd0;
            r_dst   <= 4'd0;
            r_src_a <= 4'd0;
            r_src_b <= 4'd0;
            r_fn    <= 4'd0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cmd   <= w_cmd;
            r_dst   <= w_dst;
            r_src_a <= w_src_a;
            r_src_b <= w_src_b;
            r_fn    <= w_fn;
            r_cnt   <= w_cnt;
        end
    end

    // Next state; fields are only loaded from the ports when IDLE accepts
    always_comb begin
        w_next_state = r_state;
        w_cmd        = r_cmd;
        w_dst        = r_dst;
        w_src_a      = r_src_a;
        w_src_b      = r_src_b;
        w_fn         = r_fn;
        w_cnt        = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_READ;
                    w_cmd        = cmd;
                    w_dst        = dst;
                    w_src_a      = srcA;
                    w_src_b      = srcB;
                    w_fn         = fn;
                    w_cnt        = rpt;
                end
            end
            ST_READ: w_next_state = ST_EXEC;
            ST_EXEC: begin
                if (r_cnt != 4'd0) begin
                    w_cnt        = r_cnt - 4'd1;
                    w_next_state = ST_READ;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs
    // line up with the state they describe
    always_comb begin
        w_busy   = (w_next_state == ST_READ) || (w_next_state == ST_EXEC);
        w_done   = (w_next_state == ST_DONE);
        w_exec   = (w_next_state == ST_EXEC);
        w_ie     = 1'b0;
        w_waa    = 4'd0;
        w_wea    = 1'b0;
        w_wab    = 4'd0;
        w_web    = 1'b0;
        w_raa    = 4'd0;
        w_rea    = 1'b0;
        w_rab    = 4'd0;
        w_reb    = 1'b0;
        w_s_alu1 = 4'd0;
        w_s_alu2 = 4'd0;
        w_oe     = 1'b0;
        if (w_busy) begin
            case (w_cmd)
                CMD_LOAD: begin
                    w_ie  = 1'b1;
                    w_wab = w_dst;
                    w_web = w_exec;
                end
                CMD_ALU: begin
                    w_raa    = w_src_a;
                    w_rab    = w_src_b;
                    w_rea    = 1'b1;
                    w_reb    = 1'b1;
                    w_s_alu1 = w_fn;
                    w_waa    = w_dst;
                    w_wea    = w_exec;
                end
                CMD_UNARY: begin
                    w_rab    = w_src_b;
                    w_reb    = 1'b1;
                    w_s_alu2 = w_fn;
                    w_wab    = w_dst;
                    w_web    = w_exec;
                end
                CMD_OUT: begin
                    w_raa    = w_src_a;
                    w_rab    = w_src_b;
                    w_rea    = 1'b1;
                    w_reb    = 1'b1;
                    w_s_alu1 = w_fn;
                    w_oe     = w_exec;
                end
                default: ;
            endcase
        end
    end

    // Output registers; reset clears every control line without a clock
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            IE     <= 1'b0;
            WAA    <= 4'd0;
            WEA    <= 1'b0;
            WAB    <= 4'd0;
            WEB    <= 1'b0;
            RAA    <= 4'd0;
            REA    <= 1'b0;
            RAB    <= 4'd0;
            REB    <= 1'b0;
            S_ALU1 <= 4'd0;
            S_ALU2 <= 4'd0;
            OE     <= 1'b0;
        end else begin
            busy   <= w_busy;
            done   <= w_done;
            IE     <= w_ie;
            WAA    <= w_waa;
            WEA    <= w_wea;
            WAB    <= w_wab;
            WEB    <= w_web;
            RAA    <= w_raa;
            REA    <= w_rea;
            RAB    <= w_rab;
            REB    <= w_reb;
            S_ALU1 <= w_s_alu1;
            S_ALU2 <= w_s_alu2;
            OE     <= w_oe;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_ctrl
//  Brief    : Randomized self-checking bench for datapath_ctrl. A reference
//             model expands each accepted command into its expected per-cycle
//             control words and compares them cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_datapath_ctrl;

    logic       CLK;
    logic       RST;
    logic       start;
    logic [1:0] cmd;
    logic [3:0] dst;
    logic [3:0] srcA;
    logic [3:0] srcB;
    logic [3:0] fn;
    logic [3:0] rpt;
    logic       busy;
    logic       done;
    logic       IE;
    logic [3:0] WAA;
    logic       WEA;
    logic [3:0] WAB;
    logic       WEB;
    logic [3:0] RAA;
    logic       REA;
    logic [3:0] RAB;
    logic       REB;
    logic [3:0] S_ALU1;
    logic [3:0] S_ALU2;
    logic       OE;

    int checks   = 0;
    int failures = 0;

    datapath_ctrl u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .cmd    (cmd),
        .dst    (dst),
        .srcA   (srcA),
        .srcB   (srcB),
        .fn     (fn),
        .rpt    (rpt),
        .busy   (busy),
        .done   (done),
        .IE     (IE),
        .WAA    (WAA),
        .WEA    (WEA),
        .WAB    (WAB),
        .WEB    (WEB),
        .RAA    (RAA),
        .REA    (REA),
        .RAB    (RAB),
        .REB    (REB),
        .S_ALU1 (S_ALU1),
        .S_ALU2 (S_ALU2),
        .OE     (OE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control word layout: busy,done,IE,WAA,WEA,WAB,WEB,RAA,REA,RAB,REB,S1,S2,OE
    function automatic logic [31:0] pack(
        input logic b, input logic d, input logic ie,
        input logic [3:0] waa, input logic wea,
        input logic [3:0] wab, input logic web,
        input logic [3:0] raa, input logic rea,
        input logic [3:0] rab, input logic reb,
        input logic [3:0] s1, input logic [3:0] s2, input logic oe);
        return {b, d, ie, waa, wea, wab, web, raa, rea, rab, reb, s1, s2, oe};
    endfunction

    function automatic logic [31:0] observed();
        return pack(busy, done, IE, WAA, WEA, WAB, WEB, RAA, REA, RAB, REB,
                    S_ALU1, S_ALU2, OE);
    endfunction

    // Expected control word for one busy cycle of a command
    function automatic logic [31:0] busy_word(
        input logic [1:0] c, input logic [3:0] d, input logic [3:0] a,
        input logic [3:0] b, input logic [3:0] f, input logic ex);
        case (c)
            2'b00:   return pack(1, 0, 1, 0, 0, d, ex, 0, 0, 0, 0, 0, 0, 0);
            2'b01:   return pack(1, 0, 0, d, ex, 0, 0, a, 1, b, 1, f, 0, 0);
            2'b10:   return pack(1, 0, 0, 0, 0, d, ex, 0, 0, b, 1, 0, f, 0);
            default: return pack(1, 0, 0, 0, 0, 0, 0, a, 1, b, 1, f, 0, ex);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bit 32 marks an EXEC cycle; bits 31:0 are the expected control word
    logic [32:0] sched[$];
    logic [32:0] cur;
    int          next_rst;
    int          r;

    initial begin
        RST   = 1'b1;
        start = 1'b0;
        cmd   = 2'd0;
        dst   = 4'd0;
        srcA  = 4'd0;
        srcB  = 4'd0;
        fn    = 4'd0;
        rpt   = 4'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset", observed(), 32'd0);
        RST      = 1'b0;
        cur      = '0;
        next_rst = 300;

        for (int k = 0; k < 4000; k++) begin
            @(negedge CLK);
            chk("cycle", observed(), cur[31:0]);

            // Abort an in-flight command from its EXEC cycle
            if (k >= next_rst && cur[32]) begin
                #1 RST = 1'b1;
                #1 chk("rst_async", observed(), 32'd0);
                start = 1'b0;
                @(posedge CLK);
                #1 chk("rst_hold", observed(), 32'd0);
                @(negedge CLK);
                RST = 1'b0;
                sched.delete();
                cur      = '0;
                next_rst = k + 700;
                continue;
            end

            start = ($urandom_range(0, 2) != 0);
            cmd   = 2'($urandom);
            dst   = 4'($urandom);
            srcA  = 4'($urandom);
            srcB  = 4'($urandom);
            fn    = 4'($urandom);
            r     = $urandom_range(0, 9);
            rpt   = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 3));

            @(posedge CLK);
            if (sched.size() != 0) begin
                cur = sched.pop_front();
            end else if (cur[31:30] == 2'b00 && start) begin
                for (int i = 0; i <= int'(rpt); i++) begin
                    sched.push_back({1'b0, busy_word(cmd, dst, srcA, srcB, fn, 1'b0)});
                    sched.push_back({1'b1, busy_word(cmd, dst, srcA, srcB, fn, 1'b1)});
                end
                sched.push_back({1'b0, 32'h4000_0000});
                cur = sched.pop_front();
            end else begin
                cur = '0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
